// File: rtl/seq_det_ctrl.sv
// Serialiser and frame controller for the 1-bit Mealy sequence detector.
// Define SEQ_DET_CTRL_LSB_FIRST_EN to shift words out LSB first (default is MSB first).
module seq_det_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             det_x,
  input  logic             det_y,
  output logic             det_clr_n,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_cnt,
  output logic             frame_done,
  output logic             err,
  input  logic             err_clr
);

  localparam int BC_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, ERR} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic             last_q, last_d;
  logic             det_x_q, det_x_d;
  logic             det_clr_n_q, det_clr_n_d;
  logic             match_pulse_q, match_pulse_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic             err_q, err_d;
  logic             last_bit;

  function automatic logic word_head(input logic [WIDTH-1:0] w);
`ifdef SEQ_DET_CTRL_LSB_FIRST_EN
    return w[0];
`else
    return w[WIDTH-1];
`endif
  endfunction

  function automatic logic [WIDTH-1:0] word_shift(input logic [WIDTH-1:0] w);
`ifdef SEQ_DET_CTRL_LSB_FIRST_EN
    return {1'b0, w[WIDTH-1:1]};
`else
    return {w[WIDTH-2:0], 1'b0};
`endif
  endfunction

  assign last_bit = (bit_cnt_q == '0);

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    last_d        = last_q;
    match_cnt_d   = match_cnt_q;
    match_pulse_d = 1'b0;
    in_ready      = 1'b0;
    frame_done    = 1'b0;
    err_d         = err_clr ? 1'b0 : err_q;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shreg_d     = in_data;
          bit_cnt_d   = BC_W'(WIDTH - 1);
          last_d      = in_last;
          match_cnt_d = '0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (det_y) begin
          match_pulse_d = 1'b1;
          if (match_cnt_q != '1) match_cnt_d = match_cnt_q + CNT_W'(1);
        end
        if (!last_bit) begin
          shreg_d   = word_shift(shreg_q);
          bit_cnt_d = bit_cnt_q - BC_W'(1);
        end else if (last_q) begin
          state_d = DONE;
        end else begin
          in_ready = 1'b1;
          // Next word must follow gaplessly; the detector cannot be paused.
          if (in_valid) begin
            shreg_d   = in_data;
            bit_cnt_d = BC_W'(WIDTH - 1);
            last_d    = in_last;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      ERR: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Detector-facing signals are registered from the next state so they are glitch-free.
    det_x_d     = (state_d == SHIFT) ? word_head(shreg_d) : 1'b0;
    det_clr_n_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      last_q        <= 1'b0;
      det_x_q       <= 1'b0;
      det_clr_n_q   <= 1'b0;
      match_pulse_q <= 1'b0;
      match_cnt_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      last_q        <= last_d;
      det_x_q       <= det_x_d;
      det_clr_n_q   <= det_clr_n_d;
      match_pulse_q <= match_pulse_d;
      match_cnt_q   <= match_cnt_d;
      err_q         <= err_d;
    end
  end

  assign det_x       = det_x_q;
  assign det_clr_n   = det_clr_n_q;
  assign match_pulse = match_pulse_q;
  assign match_cnt   = match_cnt_q;
  assign err         = err_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed plus randomized bench for seq_det_ctrl with a "10" Mealy detector model.
module tb_seq_det_ctrl;
  localparam int W    = 8;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic          det_x;
  logic          det_y;
  logic          det_clr_n;
  logic          match_pulse;
  logic [CW-1:0] match_cnt;
  logic          frame_done;
  logic          err;
  logic          err_clr;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [W-1:0]  words [0:3];
  bit            exp_err = 1'b0;
  logic          prev_bit;

  always #5 clk = ~clk;

  seq_det_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .det_x(det_x), .det_y(det_y), .det_clr_n(det_clr_n),
    .match_pulse(match_pulse), .match_cnt(match_cnt), .frame_done(frame_done),
    .err(err), .err_clr(err_clr)
  );

  // Detector: y = current bit 0 after a 1 since the last clear.
  always @(posedge clk or negedge det_clr_n) begin
    if (!det_clr_n) prev_bit <= 1'b0;
    else            prev_bit <= det_x;
  end
  assign det_y = !det_x && prev_bit;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Drives one frame of nw words from words[]; uflow withholds the word after the last one.
  task automatic run_frame(input int nw, input bit uflow, input bit clr_at_err);
    bit bits[$];
    bit mt[$];
    int cnt;
    int n;
    bit exp_ready;
    for (int w = 0; w < nw; w++)
      for (int k = 0; k < W; k++) begin
`ifdef SEQ_DET_CTRL_LSB_FIRST_EN
        bits.push_back(words[w][k]);
`else
        bits.push_back(words[w][W-1-k]);
`endif
      end
    n = bits.size();
    for (int i = 0; i < n; i++) mt.push_back(i > 0 && bits[i-1] && !bits[i]);

    chk("idle_ready", in_ready, 1);
    chk("idle_clr_n", det_clr_n, 0);
    in_valid = 1'b1;
    in_data  = words[0];
    in_last  = (nw == 1) && !uflow;
    @(posedge clk); @(negedge clk);
    cnt = 0;
    for (int j = 0; j < n; j++) begin
      int k = j % W;
      int w = j / W;
      exp_ready = (k == W-1) && (w < nw-1 || uflow);
      $display("cycle %0d: det_x=%0b exp=%0b match_cnt=%0d exp=%0d", j, det_x, bits[j], match_cnt, cnt);
      chk("det_x", det_x, bits[j]);
      chk("clr_n_mid", det_clr_n, 1);
      chk("done_mid", frame_done, 0);
      chk("pulse", match_pulse, (j > 0) ? mt[j-1] : 1'b0);
      chk("cnt", match_cnt, cnt);
      chk("ready", in_ready, exp_ready);
      chk("err_mid", err, exp_err);
      if (k == W-1 && w < nw-1) begin
        in_valid = 1'b1;
        in_data  = words[w+1];
        in_last  = (w+1 == nw-1) && !uflow;
      end else if (k == W-1 && uflow) begin
        in_valid = 1'b0;
        in_data  = W'($urandom_range(255));
        err_clr  = clr_at_err;
      end else begin
        in_valid = 1'($urandom_range(1));
        in_data  = W'($urandom_range(255));
        in_last  = 1'($urandom_range(1));
      end
      @(posedge clk); @(negedge clk);
      if (mt[j]) cnt = (cnt == CMAX) ? CMAX : cnt + 1;
    end
    if (uflow) exp_err = 1'b1;
    $display("frame end: words=%0d uflow=%0b frame_done=%0b err=%0b match_cnt=%0d exp=%0d",
             nw, uflow, frame_done, err, match_cnt, cnt);
    chk("end_pulse", match_pulse, mt[n-1]);
    chk("end_cnt", match_cnt, cnt);
    chk("end_det_x", det_x, 0);
    chk("end_clr_n", det_clr_n, 0);
    chk("end_ready", in_ready, 0);
    chk("end_done", frame_done, !uflow);
    chk("end_err", err, exp_err);
    in_valid = 1'b0;
    err_clr  = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("post_ready", in_ready, 1);
    chk("post_done", frame_done, 0);
    chk("post_pulse", match_pulse, 0);
    chk("post_cnt", match_cnt, cnt);
    chk("post_clr_n", det_clr_n, 0);
    chk("post_err", err, exp_err);
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_err = 1'b0;
    $display("err_clr pulse: err=%0b", err);
    chk("err_clr", err, 0);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    $display("reset: in_ready=%0b det_x=%0b clr_n=%0b cnt=%0d", in_ready, det_x, det_clr_n, match_cnt);
    chk("rst_ready", in_ready, 1);
    chk("rst_det_x", det_x, 0);
    chk("rst_clr_n", det_clr_n, 0);
    chk("rst_pulse", match_pulse, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_err", err, 0);
    rst = 1'b1;
    @(negedge clk);

    words[0] = 8'hA5;
    run_frame(1, 1'b0, 1'b0);
    chk("a5_cnt", match_cnt, 3);

    words[0] = 8'h01; words[1] = 8'h00;
    run_frame(2, 1'b0, 1'b0);
    chk("cross_cnt", match_cnt, 1);

    words[0] = 8'hAA; words[1] = 8'hAA;
    run_frame(2, 1'b0, 1'b0);
    chk("sat_cnt", match_cnt, CMAX);

    words[0] = 8'h00;
    run_frame(1, 1'b0, 1'b0);
    chk("zero_cnt", match_cnt, 0);

    // Underflow with err_clr coinciding with the error entry: set wins.
    words[0] = 8'h01;
    run_frame(1, 1'b1, 1'b1);
    chk("uflow_err", err, 1);

    // Asynchronous reset in the middle of a frame.
    in_valid = 1'b1; in_data = W'($urandom_range(255)); in_last = 1'b1;
    @(posedge clk);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    in_valid = 1'b0;
    exp_err  = 1'b0;
    $display("mid-frame reset: det_x=%0b clr_n=%0b cnt=%0d err=%0b", det_x, det_clr_n, match_cnt, err);
    chk("arst_ready", in_ready, 1);
    chk("arst_det_x", det_x, 0);
    chk("arst_clr_n", det_clr_n, 0);
    chk("arst_pulse", match_pulse, 0);
    chk("arst_cnt", match_cnt, 0);
    chk("arst_done", frame_done, 0);
    chk("arst_err", err, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    words[0] = 8'hA5;
    run_frame(1, 1'b0, 1'b0);
    chk("a5_after_rst", match_cnt, 3);

    words[0] = 8'h3C; words[1] = 8'hF0;
    run_frame(2, 1'b1, 1'b0);
    pulse_err_clr();

    for (int f = 0; f < 25; f++) begin
      int nw;
      bit uf;
      int gap = $urandom_range(2);
      for (int g = 0; g < gap; g++) begin
        chk("gap_ready", in_ready, 1);
        chk("gap_det_x", det_x, 0);
        @(negedge clk);
      end
      nw = $urandom_range(1, 3);
      uf = ($urandom_range(4) == 0);
      for (int w = 0; w < nw; w++) words[w] = W'($urandom_range(255));
      run_frame(nw, uf, 1'($urandom_range(1)));
      if (exp_err && $urandom_range(1) == 1) pulse_err_clr();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/seq_det_ctrl.md
# seq_det_ctrl

Front-end sequencer for the team's 1-bit serial Mealy sequence detector. It accepts parallel words over a valid/ready handshake and serialises them, one bit per clock, onto the detector's `x` input. It samples the detector's combinational `y` output and counts matches per frame. It also owns the detector's active-low reset, holding the detector cleared between frames and on errors so that every frame starts from the detector's initial state.

## Interface
- `WIDTH`, 8: bits per input word, ≥ 2.
- `CNT_W`, 16: width of the per-frame match counter.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `in_data` in WIDTH: word to serialise.
- `in_valid` in 1: `in_data`/`in_last` valid.
- `in_last` in 1: word is final word of frame.
- `in_ready` out 1: controller accepts a word this cycle.
- `det_x` out 1: serial bit to detector (registered).
- `det_y` in 1: detector Mealy output for current `det_x`.
- `det_clr_n` out 1: detector reset, active-low (registered).
- `match_pulse` out 1: one-cycle pulse, a match was sampled on the previous edge.
- `match_cnt` out CNT_W: matches in current/most recent frame.
- `frame_done` out 1: one-cycle pulse, frame completed cleanly.
- `err` out 1: sticky underflow flag.
- `err_clr` in 1: synchronous clear of `err`.

## Operation
- FSM states: IDLE, SHIFT, DONE, ERR.
- A word is accepted on an edge where `in_valid && in_ready`.
- IDLE:
  - `in_ready`=1, `det_clr_n`=0.
  - On accept: load the shift register, set `bit_cnt`=WIDTH-1, latch `in_last`, clear `match_cnt`, go to SHIFT.
- SHIFT:
  - `det_clr_n`=1.
  - `det_x` = current shift-register head.
  - On each edge, if `det_y`=1: `match_cnt`+1 (saturates at 2^CNT_W-1) and `match_pulse`=1 next cycle.
  - Below the last bit: shift, `bit_cnt`-1.
- Last bit of SHIFT (`bit_cnt`==0):
  - If latched last=1: `in_ready`=0, go to DONE.
  - Else: `in_ready`=1.
    - If `in_valid`: reload from `in_data`, latch `in_last`, stay in SHIFT. The bitstream is contiguous and the detector is not cleared; `match_cnt` is not cleared.
    - If `!in_valid`: underflow. Go to ERR. The detector cannot stall, so the frame is aborted.
- In SHIFT below the last bit, `in_ready`=0.
- DONE: `frame_done`=1, `det_clr_n`=0, `in_ready`=0, go to IDLE.
- ERR: `err`←1, `det_clr_n`=0, `in_ready`=0, no `frame_done`, go to IDLE.
- `match_cnt` holds its value after DONE/ERR until the next frame-start accept.
- `err_clr`:
  - Clears `err` on the next edge.
  - If `err_clr` coincides with ERR entry, set wins.
  - `err` does not block new frames.
- `det_x`=0 whenever not in SHIFT.

## Timing
- Reset values:
  - state IDLE
  - `in_ready`=1 (decoded from IDLE)
  - `det_x`=0
  - `det_clr_n`=0
  - `match_pulse`=0
  - `match_cnt`=0
  - `frame_done`=0
  - `err`=0
- Reset is asynchronous and takes effect immediately mid-frame. `det_clr_n` drops with it.
- Bit k (k=0..WIDTH-1) of a word accepted at edge E is on `det_x` during the cycle after edge E+k.
- Throughput: one bit per clock, back-to-back words gapless. A word accepted from IDLE costs one idle cycle before its first bit.
- `match_pulse`/`match_cnt` update on the edge closing the matching bit cycle.
- `frame_done` is high in the cycle after the last bit's edge, i.e. WIDTH cycles after the last word's accept edge. The final `match_cnt` is valid in that same cycle.
- `det_clr_n` and `det_x` come straight from flops: glitch-free into the detector's async reset.

## Configuration
- `SEQ_DET_CTRL_LSB_FIRST_EN`:
  - Defined: words are serialised LSB first (bit 0 first).
  - Undefined (default): MSB first (bit WIDTH-1 first).
  - Only the shift direction changes; timing is identical.

## Test plan
Bench detector model: `det_y` = `det_x`==0 && previous bit since clear ==1 (the team detector's "10" behaviour).
- Single frame, `in_data`=0xA5 with `in_last`=1, WIDTH=8 → bits 1,0,1,0,0,1,0,1; `match_cnt`=3; three `match_pulse`s; `frame_done` 8 cycles after accept; `det_clr_n` low in DONE.
- Two-word frame 0x01 then 0x00 (`in_last` on the second), `in_valid` held → `in_ready` high on the first word's bit-7 cycle; gapless 16 bits; `match_cnt`=1 (cross-word match); `det_clr_n` never low mid-frame.
- Underflow: 0x01 with `in_last`=0, then `in_valid`=0 → `err`=1, no `frame_done`, `det_clr_n` low next cycle, IDLE after. `err_clr` pulse → `err`=0.
- Saturation, CNT_W=2, 0xAA → 4 matches, `match_cnt`=3. Next frame 0x00 → `match_cnt` cleared to 0 on accept.
- Assert `rst`=0 at bit 4 of a frame → all outputs at reset values asynchronously; after release, a new 0xA5 frame gives 3.
- With `SEQ_DET_CTRL_LSB_FIRST_EN`: 0x01 → bit sequence 1,0,…,0; `match_cnt`=1.
